mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for a shared 4-to-1 datapath mux. Four requesters
//   (e.g. writeback/forwarding sources) compete for one downstream port; the block owns
//   the 2-bit mux select, grants one requester at a time with bounded burst length,
//   and registers the selected word into a one-entry output stage with valid/ready.
// PARAMETERS
//   SIZE      32  width of each data input and of out_data
//   MAX_HOLD  4   max consecutive beats one requester may keep the grant while others wait (>=1)
// PORTS
//   clk        in   1       single clock, rising edge
//   reset      in   1       synchronous, active-high
//   in_valid   in   4       per-requester data valid; bit i pairs with a<i>
//   a0..a3     in   SIZE    requester data words
//   in_ready   out  4       per-requester accept; at most one bit high, only for the granted requester
//   sel        out  2       current mux select (index of granted requester)
//   grant      out  4       one-hot grant; all-zero when idle
//   out_valid  out  1       output register holds a word
//   out_data   out  SIZE    registered selected word
//   out_ready  in   1       downstream accepts out_data this cycle
// BEHAVIOUR
//   Reset (sync, high, any state): state=IDLE, sel=0, grant=0, ptr=0, hold_cnt=0,
//     out_valid=0, out_data=0, in_ready=0. A word held in the output register is discarded.
//   States: IDLE (no grant), GRANT (grant[sel]=1).
//   Pick: winner = first i with in_valid[i]=1 scanning ptr, ptr+1, ... mod 4.
//   IDLE: if |in_valid -> next GRANT, sel=winner, hold_cnt=0. Grant is registered:
//     valid seen in cycle N -> grant/in_ready visible in N+1.
//   GRANT: in_ready[sel] = !out_valid | out_ready; all other in_ready bits 0.
//     Beat = in_valid[sel] & in_ready[sel]: out_data<=a[sel], out_valid<=1, hold_cnt++.
//     Out drain: out_valid & out_ready & no beat -> out_valid<=0. Beat and drain in same
//       cycle -> out_valid stays 1 with new data (full throughput, 1 beat/cycle).
//   Release from GRANT (evaluated at clock edge, ptr<=sel+1 mod 4 on every release):
//     a) in_valid[sel]=0 -> re-pick among others; none valid -> IDLE, grant=0.
//     b) beat with hold_cnt==MAX_HOLD-1 and any other in_valid high -> switch to winner
//        of the others, hold_cnt=0, no idle cycle between grants.
//     c) beat with hold_cnt==MAX_HOLD-1 and no others valid -> keep grant, hold_cnt=0, ptr unchanged.
//   hold_cnt width clog2(MAX_HOLD)+1; never exceeds MAX_HOLD-1; resets to 0 on new grant.
//   Switching never drops or duplicates a beat; sel changes only at grant changes.
//   Backpressure: out_valid=1 & out_ready=0 -> in_ready=0, out_data stable, grant held,
//     hold_cnt frozen. A requester dropping in_valid while stalled still triggers release (a).
//   Latency: first request from IDLE -> out_valid 2 cycles later; back-to-back under grant: 1.
//   sel in IDLE keeps its last value; grant=0 is the only idle indicator.
// TESTING
//   1 Reset: assert reset 2 cycles with all in_valid=1 -> grant=0, in_ready=0, out_valid=0, out_data=0.
//   2 Single req: in_valid=4'b0100, a2=32'hDEAD_BEEF, out_ready=1 -> cycle+1 grant=4'b0100,
//     sel=2, in_ready=4'b0100; cycle+2 out_valid=1, out_data=32'hDEAD_BEEF.
//   3 Fairness: all 4 valid continuously, MAX_HOLD=4, out_ready=1 -> grant order 0,1,2,3,0
//     with exactly 4 beats each, no idle cycle between grants.
//   4 Backpressure: granted req 1 streaming, out_ready=0 for 5 cycles -> in_ready=0,
//     out_data frozen, hold_cnt frozen; on out_ready=1 streaming resumes, no beat lost/duplicated.
//   5 Sole requester: only req 3 valid for 10 beats -> grant stays 4'b1000 all 10 beats
//     (hold_cnt wraps), ptr remains 3.
//   6 Reset mid-burst: reset during beat 2 of req 0 with out_valid=1 -> next cycle all
//     outputs at reset values; after release, re-arbitration starts from ptr=0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 arbiter driving a registered output stage; first word out 2 cycles after a request, then 1 word/cycle.
// Backpressure: a stalled output drops in_ready and freezes the data, grant and burst count.
module mux4_rr_arbiter #(
    parameter int SIZE     = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      in_valid,
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] a2,
    input  logic [SIZE-1:0] a3,
    output logic [3:0]      in_ready,
    output logic [1:0]      sel,
    output logic [3:0]      grant,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    input  logic            out_ready
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [SIZE-1:0] out_data_q, out_data_d;

    logic [SIZE-1:0] sel_dat;
    logic [1:0]      nxt;
    logic            beat;
    logic [2:0]      idle_pick;
    logic [2:0]      other_pick;

    // Returns {found, index} of the first set request scanning from start upward, wrapping.
    function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        logic [1:0] i;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            i = start + 2'(k);
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = i;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        case (sel_q)
            2'd0:    sel_dat = a0;
            2'd1:    sel_dat = a1;
            2'd2:    sel_dat = a2;
            default: sel_dat = a3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        grant      = (state_q == GRANT) ? (4'b0001 << sel_q) : 4'b0000;
        in_ready   = (!out_valid_q || out_ready) ? grant : 4'b0000;
        beat       = |(in_valid & in_ready);
        nxt        = sel_q + 2'd1;
        idle_pick  = pick(in_valid, ptr_q);
        // The current owner scans last, so masking it leaves only the others in fair order.
        other_pick = pick(in_valid & ~grant, nxt);

        if (beat) begin
            out_data_d  = sel_dat;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (idle_pick[2]) begin
                    state_d    = GRANT;
                    sel_d      = idle_pick[1:0];
                    hold_cnt_d = '0;
                end
            end
            default: begin
                if (!in_valid[sel_q]) begin
                    ptr_d      = nxt;
                    hold_cnt_d = '0;
                    if (other_pick[2]) begin
                        sel_d = other_pick[1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end else if (beat) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        if (other_pick[2]) begin
                            sel_d = other_pick[1:0];
                            ptr_d = nxt;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations plus a long randomized run
// compared every cycle against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [31:0] a [4];
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic [3:0]  grant;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int compared;
    int mismatched;

    mux4_rr_arbiter #(.SIZE(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a0        (a[0]),
        .a1        (a[1]),
        .a2        (a[2]),
        .a3        (a[3]),
        .in_ready  (in_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_gnt;   // owner index, -1 when idle
    int          m_sel;
    int          m_ptr;
    int          m_beats; // beats in the current burst
    bit          m_ov;
    logic [31:0] m_od;
    bit          m_known;

    function automatic int pick(input logic [3:0] v, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (v[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int  g;
        int  w;
        bit  beat;
        if (reset) begin
            m_gnt = -1; m_sel = 0; m_ptr = 0; m_beats = 0; m_ov = 0; m_od = 0;
            m_known = 1;
            return;
        end
        g    = m_gnt;
        beat = (g >= 0) && in_valid[g] && (!m_ov || out_ready);
        if (beat) begin
            m_od = a[g];
            m_ov = 1;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        if (g < 0) begin
            w = pick(in_valid, m_ptr, -1);
            if (w >= 0) begin
                m_gnt = w; m_sel = w; m_beats = 0;
            end
        end else if (!in_valid[g]) begin
            m_ptr = (g + 1) % 4;
            w = pick(in_valid, (g + 1) % 4, -1);
            m_gnt = w;
            if (w >= 0) m_sel = w;
            m_beats = 0;
        end else if (beat) begin
            m_beats++;
            if (m_beats == MAX_HOLD) begin
                m_beats = 0;
                w = pick(in_valid, (g + 1) % 4, g);
                if (w >= 0) begin
                    m_gnt = w; m_sel = w; m_ptr = (g + 1) % 4;
                end
            end
        end
    endtask

    initial begin
        m_known = 0;
        forever begin
            @(negedge clk);
            #1;
            if (m_known) begin
                logic [3:0] eg;
                logic [3:0] er;
                eg = (m_gnt >= 0) ? 4'(1 << m_gnt) : 4'b0000;
                er = (m_gnt >= 0 && (!m_ov || out_ready)) ? eg : 4'b0000;
                chk("model_grant", 32'(grant), 32'(eg));
                chk("model_sel", 32'(sel), 32'(m_sel));
                chk("model_in_ready", 32'(in_ready), 32'(er));
                chk("model_out_valid", 32'(out_valid), 32'(m_ov));
                chk("model_out_data", out_data, m_od);
            end
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) a[i] = 32'h0;

        // reset held two cycles with every requester valid
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);

        // single requester
        @(negedge clk); reset = 1'b0; in_valid = 4'b0000;
        @(negedge clk); in_valid = 4'b0100; a[2] = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_sel", 32'(sel), 32'h2);
        chk("single_in_ready", 32'(in_ready), 32'h4);
        @(negedge clk); #1;
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_out_data", out_data, 32'hDEAD_BEEF);
        @(negedge clk); in_valid = 4'b0000;
        repeat (3) @(negedge clk);

        // fairness: all four valid, 4 beats each, no idle gap
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; in_valid = 4'hF;
        for (int i = 0; i < 4; i++) a[i] = 32'h1111_1111 * i;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk); #1;
            chk("fair_grant", 32'(grant), 32'(1 << ((k / 4) % 4)));
        end

        // sole requester keeps the grant across hold wraps
        @(negedge clk); in_valid = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            chk("sole_grant", 32'(grant), 32'h8);
        end
        @(negedge clk); in_valid = 4'b0000;
        @(negedge clk); #1;
        chk("sole_release_idle", 32'(grant), 32'h0);
        @(negedge clk); in_valid = 4'b1100;
        @(negedge clk); #1;
        chk("ptr_after_sole", 32'(grant), 32'h4);

        // backpressure on requester 1
        @(negedge clk); reset = 1'b1; in_valid = 4'b0000;
        @(negedge clk); reset = 1'b0; in_valid = 4'b0010; a[1] = 32'hB000_0000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); a[1] = 32'hB000_0000 + 32'(k);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); out_ready = 1'b0; a[1] = 32'hB000_0004; #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_data", out_data, 32'hB000_0003);
            chk("bp_grant", 32'(grant), 32'h2);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        chk("bp_resume_ready", 32'(in_ready), 32'h2);
        @(negedge clk); a[1] = 32'hB000_0005; #1;
        chk("bp_resume_data", out_data, 32'hB000_0004);
        @(negedge clk); in_valid = 4'b0000; #1;
        chk("bp_next_data", out_data, 32'hB000_0005);
        repeat (2) @(negedge clk);

        // reset during a burst from requester 0
        @(negedge clk); in_valid = 4'b0011; a[0] = 32'hC000_0000;
        @(negedge clk); a[0] = 32'hC000_0001;
        @(negedge clk); reset = 1'b1; #1;
        chk("mid_out_valid", 32'(out_valid), 32'h1);
        @(negedge clk); reset = 1'b0; in_valid = 4'b0110; #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out_data", out_data, 32'h0);
        chk("mid_rst_sel", 32'(sel), 32'h0);
        @(negedge clk); #1;
        chk("mid_rearb_grant", 32'(grant), 32'h2);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) in_valid[i] = ~in_valid[i];
                a[i] = $urandom();
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
